key_param_ctrl: RTL and testbench

Push-button tuning controller: debounces three active-low board keys and uses them to select and step a bank of NPARAM runtime parameters (thresholds, offsets, gains) feeding the vision/aiming datapath. One key cycles the selected parameter; the other two step the selected value up or down with saturation. Optional auto-repeat while a step key is held. Sits between the raw key pins and the configuration inputs of the processing pipeline, replacing ad-hoc per-key toggles.

---
 rtl/key_param_ctrl.sv | 153 +++++++++++++++
 tb/tb_key_param_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_param_ctrl.sv
// Push-button tuning controller: debounced select/inc/dec keys step a bank of NPARAM parameters.
// Optional auto-repeat on held step keys when KEY_PARAM_AUTOREPEAT_EN is defined.

module key_param_ctrl_deb #(
  parameter int TICK = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key,
  output logic deb
);
  localparam int CW = $clog2(TICK + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Debounced level flips only after TICK consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= 2'b11;
      cnt  <= '0;
      deb  <= 1'b1;
    end else begin
      sync <= {sync[0], key};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(TICK)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_param_ctrl #(
  parameter int TICK   = 1000,
  parameter int NPARAM = 4,
  parameter int WIDTH  = 8,
  parameter int INIT   = 0,
  parameter int HOLD   = 50_000_000,
  parameter int RATE   = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       key_sel,
  input  logic                       key_inc,
  input  logic                       key_dec,
  output logic [$clog2(NPARAM)-1:0]  sel,
  output logic [NPARAM*WIDTH-1:0]    params,
  output logic                       update
);
  localparam int SW = $clog2(NPARAM);
  localparam logic [WIDTH-1:0] VMAX = '1;

  if (TICK < 1 || NPARAM < 2 || WIDTH < 1 || WIDTH > 16 || HOLD < 1 || RATE < 1) begin : g_bad_param
    $error("key_param_ctrl: illegal parameter");
  end

  logic [2:0] raw, deb, deb_q, press;
  assign raw = {key_dec, key_inc, key_sel};

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_param_ctrl_deb #(.TICK(TICK)) u_deb (
      .clk  (clk),
      .rstn (rstn),
      .key  (raw[i]),
      .deb  (deb[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) deb_q <= '1;
    else       deb_q <= deb;
  end
  assign press = deb_q & ~deb;

  // A step press only counts while the opposite key is released.
  logic up_ev, dn_ev, step_up, step_dn;
  assign up_ev = press[1] & deb[2];
  assign dn_ev = press[2] & deb[1];

`ifdef KEY_PARAM_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REP} st_t;
  localparam int RMAX = (HOLD > RATE) ? HOLD : RATE;
  localparam int CW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
  localparam logic [CW-1:0] RATE_M1 = CW'(RATE - 1);

  st_t           st;
  logic [CW-1:0] cnt, lim;
  logic          dir, held, fire;

  assign held    = ~(~deb[1] & ~deb[2]) & (dir ? ~deb[1] : ~deb[2]);
  assign lim     = (st == S_WAIT) ? HOLD_M1 : RATE_M1;
  assign fire    = (st != S_IDLE) && held && (cnt == lim);
  assign step_up = (st == S_IDLE) ? up_ev : (fire & dir);
  assign step_dn = (st == S_IDLE) ? dn_ev : (fire & ~dir);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= S_IDLE;
      cnt <= '0;
      dir <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (up_ev | dn_ev) begin
          st  <= S_WAIT;
          dir <= up_ev;
          cnt <= '0;
        end
        default: begin
          if (!held) begin
            st  <= S_IDLE;
            cnt <= '0;
          end else if (cnt == lim) begin
            st  <= S_REP;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign step_up = up_ev;
  assign step_dn = dn_ev;
`endif

  logic [NPARAM-1:0][WIDTH-1:0] prm;
  assign params = prm;

  // Step targets the sel value from before this edge; sel may advance on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel    <= '0;
      prm    <= {NPARAM{WIDTH'(INIT)}};
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (press[0]) sel <= (sel == SW'(NPARAM - 1)) ? '0 : sel + 1'b1;
      if (step_up && prm[sel] != VMAX) begin
        prm[sel] <= prm[sel] + 1'b1;
        update   <= 1'b1;
      end else if (step_dn && prm[sel] != '0) begin
        prm[sel] <= prm[sel] - 1'b1;
        update   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: TICK=4, NPARAM=4, WIDTH=8, HOLD=20, RATE=5.
module tb_key_param_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       key_sel, key_inc, key_dec;
  logic [1:0] sel;
  logic [31:0] params;
  logic       update;
  int n_chk = 0, n_pass = 0, upd_cnt = 0, snap, cnt;

  key_param_ctrl #(.TICK(4), .NPARAM(4), .WIDTH(8), .INIT(0), .HOLD(20), .RATE(5)) dut (
    .clk(clk), .rstn(rstn), .key_sel(key_sel), .key_inc(key_inc), .key_dec(key_dec),
    .sel(sel), .params(params), .update(update)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (update) upd_cnt <= upd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    case (k)
      0: key_sel = 1'b0;
      1: key_inc = 1'b0;
      default: key_dec = 1'b0;
    endcase
    cyc(10);
    key_sel = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
    cyc(10);
  endtask

  initial begin
    rstn = 1'b0; key_sel = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
    cyc(3);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_params", params, 0);
    chk("rst_update", 32'(update), 0);
    rstn = 1'b1;
    cyc(2);

    // select wraps 3 -> 0 without touching parameters
    press(0); press(0); press(0);
    chk("sel_3", 32'(sel), 3);
    press(0);
    chk("sel_wrap", 32'(sel), 0);
    chk("sel_no_update", 32'(upd_cnt), 0);

    // glitch shorter than TICK is ignored
    key_inc = 1'b0; cyc(2); key_inc = 1'b1; cyc(12);
    chk("glitch_params", params, 0);

    // latency: first low sample at edge 0, value visible after edge 7
    key_inc = 1'b0;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_before", 32'(params[7:0]), 0);
    @(posedge clk); @(negedge clk);
    chk("lat_value", 32'(params[7:0]), 1);
    chk("lat_update", 32'(update), 1);
    @(posedge clk); @(negedge clk);
    chk("lat_update_pulse", 32'(update), 0);
    #4; key_inc = 1'b1;
    cyc(15);
    chk("lat_one_step", 32'(upd_cnt), 1);

    // saturate params[1] at 255
    press(0);
    chk("sel_1", 32'(sel), 1);
    for (int i = 0; i < 255; i++) press(1);
    chk("sat_top", 32'(params[15:8]), 255);
    chk("sat_updates", 32'(upd_cnt), 256);
    press(1);
    chk("sat_hold", 32'(params[15:8]), 255);
    chk("sat_no_update", 32'(upd_cnt), 256);
    press(0);
    press(2);
    chk("floor_hold", 32'(params[23:16]), 0);
    chk("floor_no_update", 32'(upd_cnt), 256);

    // select and increment together: step hits old index 2
    key_sel = 1'b0; key_inc = 1'b0;
    cyc(10);
    key_sel = 1'b1; key_inc = 1'b1;
    cyc(10);
    chk("same_cyc_param", 32'(params[23:16]), 1);
    chk("same_cyc_sel", 32'(sel), 3);
    chk("same_cyc_p3", 32'(params[31:24]), 0);

    // both step keys held: nothing happens, nor on release
    snap = upd_cnt;
    key_inc = 1'b0; key_dec = 1'b0;
    cyc(100);
    chk("dual_held", 32'(params[31:24]), 0);
    key_inc = 1'b1; key_dec = 1'b1;
    cyc(20);
    chk("dual_release", 32'(params[31:24]), 0);
    chk("dual_no_update", 32'(upd_cnt - snap), 0);

    // held step key: count update pulses over 40 cycles from the first step
    key_inc = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30 && cnt == 0; i++) begin
      @(negedge clk);
      if (update) cnt = 1;
    end
    chk("hold_first_step", 32'(cnt), 1);
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      if (update) cnt++;
    end
`ifdef KEY_PARAM_AUTOREPEAT_EN
    chk("hold_steps", 32'(cnt), 5);
`else
    chk("hold_steps", 32'(cnt), 1);
    chk("hold_value", 32'(params[31:24]), 1);
`endif
    key_inc = 1'b1;
    cyc(20);

    // asynchronous reset mid-cycle, then key held through reset release
    key_sel = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_params", params, 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_update", 32'(update), 0);
    cyc(3);
    rstn = 1'b1;
    cyc(15);
    chk("held_thru_rst_sel", 32'(sel), 1);
    chk("held_thru_rst_params", params, 0);
    key_sel = 1'b1;
    cyc(15);
    chk("held_thru_rst_once", 32'(sel), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
